scaler_frame_ctrl: RTL and testbench
====================================

Name: scaler_frame_ctrl

Overview:
Frame sequencer for streamScaler.
- Launches each frame: pulses start, enforces a start-to-data gap, then gates the pixel source into dIn/dInValid/nextDin.
- Throttles the output side via nextDout and counts output pixels to detect frame completion.
- Sits between the pixel source / frame-buffer reader and streamScaler, and between streamScaler and the pixel sink / frame-buffer writer.

Parameters:
IN_X_W, 11, width of input X resolution/counter
IN_Y_W, 11, width of input Y resolution/counter
OUT_X_W, 11, width of output X resolution/counter
OUT_Y_W, 11, width of output Y resolution/counter
START_LEN, 2, cycles sc_start is held high
START_GAP, 4, cycles after start deassertion before sc_din_valid may assert

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
frame_req  in  1  request frame; level, sampled in IDLE and DONE
in_x_res  in  IN_X_W  input width minus 1
in_y_res  in  IN_Y_W  input height minus 1
out_x_res  in  OUT_X_W  output width minus 1
out_y_res  in  OUT_Y_W  output height minus 1
src_valid  in  1  source pixel available
src_ready  out  1  source pixel consumed this cycle
sc_start  out  1  to streamScaler start
sc_din_valid  out  1  to streamScaler dInValid
sc_next_din  in  1  from streamScaler nextDin
snk_ready  in  1  sink can take a pixel
sc_next_dout  out  1  to streamScaler nextDout
sc_dout_valid  in  1  from streamScaler dOutValid
out_x  out  OUT_X_W  X of pixel currently on dOut
out_y  out  OUT_Y_W  Y of pixel currently on dOut
out_last  out  1  current dOut pixel is last of frame
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse at frame end
err  out  1  sticky: dOutValid seen in IDLE, or output overrun

Behaviour:
Reset:
- All outputs 0, counters 0, state IDLE. Reset mid-frame aborts immediately; there is no partial-frame completion.

States:
- IDLE: if frame_req, latch the four resolution inputs and go to START.
- START: sc_start=1 for START_LEN cycles, then go to GAP.
- GAP: all outputs inactive for START_GAP cycles, then go to STREAM.
- STREAM:
  - sc_din_valid = src_valid.
  - src_ready = src_valid & sc_next_din (combinational).
  - Accepted pixel = src_valid & sc_next_din. Each accepted pixel advances in_x; in_x wraps at latched in_x_res and increments in_y.
  - On acceptance at in_x==in_x_res and in_y==in_y_res, go to DRAIN. sc_din_valid and src_ready are 0 from the next cycle.
- DRAIN: wait for the output count to complete.
- DONE: frame_done=1 for one cycle. If frame_req=1, go to START with a fresh config latch; otherwise go to IDLE.

Output side (active in START..DRAIN):
- sc_next_dout = snk_ready, registered (1-cycle delay); 0 in IDLE/DONE.
- Each sc_dout_valid cycle is one output pixel. out_x/out_y are combinational from the counters; counters advance after the pixel.
- out_x wraps at out_x_res and increments out_y.
- out_last = sc_dout_valid & out_x==out_x_res & out_y==out_y_res.
- The out_last pixel moves the FSM to DONE (from STREAM or DRAIN) on the next cycle. Output completing before input is legal; input acceptance stops at once.
- Output counters clear on DONE→START and DONE→IDLE.

busy = state != IDLE.

err (sticky until rst) sets on:
- sc_dout_valid in IDLE;
- sc_dout_valid in DONE.

Config inputs are ignored while busy. Widths are not checked; in_x_res=0 is legal (1-pixel lines).

Test Plan:
- 4x3 to 2x2 (res 3/2/1/1), src_valid and snk_ready always 1, frame_req pulsed: sc_start high 2 cycles, 4-cycle gap, exactly 12 src_ready, 4 dOut pixels with coords (0,0)(1,0)(0,1)(1,1), out_last on the 4th, frame_done 1 cycle later, busy falls.
- Same config, src_valid toggling 1/0: src_ready never high when src_valid=0; in_x/in_y still reach 3/2 after exactly 12 accepts.
- frame_req held high for 3 frames: three frame_done pulses, each followed by a sc_start burst; config changed mid-frame takes effect only from the next frame.
- snk_ready=0 for 10 cycles during DRAIN: sc_next_dout low one cycle later and stays low; no frame_done until the output count completes.
- rst asserted mid-STREAM: next cycle all outputs 0, state IDLE; a new frame_req restarts cleanly with counters at 0.
- sc_dout_valid forced high in IDLE: err=1, stays 1 across frames until rst.

Source files
------------

// File: rtl/scaler_frame_ctrl.sv
// Frame sequencer around streamScaler: start pulse, start-to-data gap, input gating, output pixel counting.
// Latency: frame_req -> sc_start 1 cycle; sc_next_dout follows snk_ready by 1 cycle; frame_done 1 cycle after out_last.
// Backpressure: input side stalls on src_valid/sc_next_din; output side throttled by registered snk_ready.
module scaler_frame_ctrl #(
    parameter int IN_X_W    = 11,
    parameter int IN_Y_W    = 11,
    parameter int OUT_X_W   = 11,
    parameter int OUT_Y_W   = 11,
    parameter int START_LEN = 2,
    parameter int START_GAP = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_req,
    input  logic [IN_X_W-1:0]  in_x_res,
    input  logic [IN_Y_W-1:0]  in_y_res,
    input  logic [OUT_X_W-1:0] out_x_res,
    input  logic [OUT_Y_W-1:0] out_y_res,
    input  logic               src_valid,
    output logic               src_ready,
    output logic               sc_start,
    output logic               sc_din_valid,
    input  logic               sc_next_din,
    input  logic               snk_ready,
    output logic               sc_next_dout,
    input  logic               sc_dout_valid,
    output logic [OUT_X_W-1:0] out_x,
    output logic [OUT_Y_W-1:0] out_y,
    output logic               out_last,
    output logic               busy,
    output logic               frame_done,
    output logic               err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_GAP,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int PH_MAX = (START_LEN > START_GAP) ? START_LEN : START_GAP;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    state_t             state;
    logic [PH_W-1:0]    ph_cnt;
    logic [IN_X_W-1:0]  in_x_res_q;
    logic [IN_Y_W-1:0]  in_y_res_q;
    logic [OUT_X_W-1:0] out_x_res_q;
    logic [OUT_Y_W-1:0] out_y_res_q;
    logic [IN_X_W-1:0]  in_x;
    logic [IN_Y_W-1:0]  in_y;
    logic [OUT_X_W-1:0] out_x_cnt;
    logic [OUT_Y_W-1:0] out_y_cnt;
    logic               snk_q;
    logic               err_q;

    logic               active;
    logic               accept;
    logic               in_end;
    logic               out_end;
    logic               out_px;

    // Datapath decodes: output side is live from START through DRAIN; input only accepted in STREAM.
    always_comb begin
        active       = (state == S_START) || (state == S_GAP) ||
                       (state == S_STREAM) || (state == S_DRAIN);
        accept       = (state == S_STREAM) && src_valid && sc_next_din;
        in_end       = (in_x == in_x_res_q) && (in_y == in_y_res_q);
        out_end      = (out_x_cnt == out_x_res_q) && (out_y_cnt == out_y_res_q);
        out_px       = active && sc_dout_valid;
        out_last     = out_px && out_end;
        src_ready    = accept;
        sc_din_valid = (state == S_STREAM) && src_valid;
        sc_start     = (state == S_START);
        sc_next_dout = active && snk_q;
        out_x        = out_x_cnt;
        out_y        = out_y_cnt;
        busy         = (state != S_IDLE);
        frame_done   = (state == S_DONE);
        err          = err_q;
    end

    // Frame sequencer plus input/output pixel counters; config is latched only when a frame launches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            ph_cnt      <= '0;
            in_x_res_q  <= '0;
            in_y_res_q  <= '0;
            out_x_res_q <= '0;
            out_y_res_q <= '0;
            in_x        <= '0;
            in_y        <= '0;
            out_x_cnt   <= '0;
            out_y_cnt   <= '0;
        end else begin
            // Output counters step after each pixel; the last pixel wraps them back to the origin.
            if (out_px) begin
                if (out_x_cnt == out_x_res_q) begin
                    out_x_cnt <= '0;
                    out_y_cnt <= out_end ? '0 : out_y_cnt + OUT_Y_W'(1);
                end else begin
                    out_x_cnt <= out_x_cnt + OUT_X_W'(1);
                end
            end

            case (state)
                S_IDLE: begin
                    if (frame_req) begin
                        in_x_res_q  <= in_x_res;
                        in_y_res_q  <= in_y_res;
                        out_x_res_q <= out_x_res;
                        out_y_res_q <= out_y_res;
                        in_x        <= '0;
                        in_y        <= '0;
                        ph_cnt      <= '0;
                        state       <= S_START;
                    end
                end
                S_START: begin
                    if (ph_cnt == PH_W'(START_LEN - 1)) begin
                        ph_cnt <= '0;
                        state  <= S_GAP;
                    end else begin
                        ph_cnt <= ph_cnt + PH_W'(1);
                    end
                end
                S_GAP: begin
                    if (ph_cnt == PH_W'(START_GAP - 1)) begin
                        ph_cnt <= '0;
                        state  <= S_STREAM;
                    end else begin
                        ph_cnt <= ph_cnt + PH_W'(1);
                    end
                end
                S_STREAM: begin
                    if (accept) begin
                        if (in_x == in_x_res_q) begin
                            in_x <= '0;
                            in_y <= in_y + IN_Y_W'(1);
                        end else begin
                            in_x <= in_x + IN_X_W'(1);
                        end
                    end
                    // Output may finish first; that ends the frame and stops input at once.
                    if (out_last) begin
                        state <= S_DONE;
                    end else if (accept && in_end) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (out_last) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    out_x_cnt <= '0;
                    out_y_cnt <= '0;
                    if (frame_req) begin
                        in_x_res_q  <= in_x_res;
                        in_y_res_q  <= in_y_res;
                        out_x_res_q <= out_x_res;
                        out_y_res_q <= out_y_res;
                        in_x        <= '0;
                        in_y        <= '0;
                        ph_cnt      <= '0;
                        state       <= S_START;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Sink readiness is registered once; gating to the active window happens in the decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            snk_q <= 1'b0;
        end else begin
            snk_q <= snk_ready;
        end
    end

    // Sticky error: scaler output appearing while no frame is being collected.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (sc_dout_valid && ((state == S_IDLE) || (state == S_DONE))) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_scaler_frame_ctrl.sv
// Bench for scaler_frame_ctrl: frame-level reference model compared every cycle, plus directed checks.
// Stimulus is issued #1 after the rising edge; outputs are compared on the falling edge.
// Every wait on the DUT is bounded so the run always reaches its summary line.
module tb_scaler_frame_ctrl;

    localparam int SL = 2;
    localparam int SG = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_req = 1'b0;
    logic [10:0] in_x_res = 11'd3;
    logic [10:0] in_y_res = 11'd2;
    logic [10:0] out_x_res = 11'd1;
    logic [10:0] out_y_res = 11'd1;
    logic        src_valid = 1'b0;
    logic        sc_next_din = 1'b0;
    logic        snk_ready = 1'b0;
    logic        sc_dout_valid = 1'b0;
    logic        src_ready, sc_start, sc_din_valid, sc_next_dout;
    logic [10:0] out_x, out_y;
    logic        out_last, busy, frame_done, err;

    int n_cmp = 0;
    int n_bad = 0;
    logic tog_en = 1'b0;

    scaler_frame_ctrl #(
        .IN_X_W(11), .IN_Y_W(11), .OUT_X_W(11), .OUT_Y_W(11),
        .START_LEN(SL), .START_GAP(SG)
    ) dut (
        .clk(clk), .rst(rst), .frame_req(frame_req),
        .in_x_res(in_x_res), .in_y_res(in_y_res),
        .out_x_res(out_x_res), .out_y_res(out_y_res),
        .src_valid(src_valid), .src_ready(src_ready),
        .sc_start(sc_start), .sc_din_valid(sc_din_valid), .sc_next_din(sc_next_din),
        .snk_ready(snk_ready), .sc_next_dout(sc_next_dout), .sc_dout_valid(sc_dout_valid),
        .out_x(out_x), .out_y(out_y), .out_last(out_last),
        .busy(busy), .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    // A frame is: SL start cycles, SG quiet cycles, then input until nin pixels taken,
    // and it ends the cycle after output pixel number nout-1 (row-major in the output raster).
    int m_busy = 0, m_done = 0, m_cyc = 0, m_acc = 0, m_outn = 0, m_err = 0, m_snk = 0;
    int m_nin = 1, m_ow = 1, m_nout = 1;

    // 0 idle, 1 start, 2 gap, 3 stream, 4 drain, 5 done
    function automatic int get_phase();
        if (m_busy == 0) return 0;
        if (m_done != 0) return 5;
        if (m_cyc < SL) return 1;
        if (m_cyc < SL + SG) return 2;
        if (m_acc < m_nin) return 3;
        return 4;
    endfunction

    task automatic m_latch();
        m_nin  = (int'(in_x_res) + 1) * (int'(in_y_res) + 1);
        m_ow   = int'(out_x_res) + 1;
        m_nout = m_ow * (int'(out_y_res) + 1);
        m_cyc  = 0;
        m_acc  = 0;
        m_outn = 0;
    endtask

    always @(posedge clk) begin
        int ph;
        ph = get_phase();
        if (rst) begin
            m_busy = 0; m_done = 0; m_cyc = 0; m_acc = 0; m_outn = 0; m_err = 0; m_snk = 0;
        end else begin
            m_snk = int'(snk_ready);
            if (sc_dout_valid && (ph == 0 || ph == 5)) m_err = 1;
            if (ph == 0) begin
                if (frame_req) begin m_latch(); m_busy = 1; end
            end else if (ph == 5) begin
                m_done = 0;
                m_outn = 0;
                if (frame_req) m_latch();
                else m_busy = 0;
            end else begin
                m_cyc++;
                if (ph == 3 && src_valid && sc_next_din) m_acc++;
                if (sc_dout_valid) begin
                    if ((ph == 3 || ph == 4) && (m_outn % m_nout) == m_nout - 1) m_done = 1;
                    m_outn++;
                end
            end
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        int ph, idx;
        bit act;
        ph  = get_phase();
        act = (ph >= 1 && ph <= 4);
        idx = m_outn % m_nout;
        chk("sc_start", int'(sc_start), int'(ph == 1));
        chk("sc_din_valid", int'(sc_din_valid), int'(ph == 3 && src_valid));
        chk("src_ready", int'(src_ready), int'(ph == 3 && src_valid && sc_next_din));
        chk("sc_next_dout", int'(sc_next_dout), int'(act && m_snk != 0));
        chk("out_last", int'(out_last), int'(act && sc_dout_valid && idx == m_nout - 1));
        chk("busy", int'(busy), m_busy);
        chk("frame_done", int'(frame_done), int'(ph == 5));
        chk("err", int'(err), m_err);
        if (act && sc_dout_valid) begin
            chk("out_x", int'(out_x), idx % m_ow);
            chk("out_y", int'(out_y), idx / m_ow);
        end
    end

    // ---------------- event tallies for directed checks ----------------
    int cyc_n = 0, start_tot = 0, rdy_tot = 0, bad_rdy = 0, done_tot = 0;
    int opix = 0, last_idx = -1, last_start = 0, gap_meas = -1;
    bit armed = 0;
    int lx [4];
    int ly [4];

    always @(negedge clk) begin
        cyc_n++;
        if (sc_start) begin start_tot++; armed = 1; last_start = cyc_n; end
        if (src_ready) begin
            rdy_tot++;
            if (!src_valid) bad_rdy++;
            if (armed) begin gap_meas = cyc_n - last_start; armed = 0; end
        end
        if (frame_done) done_tot++;
        if (busy && sc_dout_valid) begin
            lx[opix % 4] = int'(out_x);
            ly[opix % 4] = int'(out_y);
            if (out_last) last_idx = opix;
            opix++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (tog_en) src_valid = ~src_valid;
    endtask

    task automatic wait_rdy(input int target, input string nm);
        int n;
        n = 0;
        while (rdy_tot < target && n < 200) begin tick(); n++; end
        chk(nm, int'(rdy_tot >= target), 1);
    endtask

    task automatic wait_done(input string nm);
        int n, base;
        n = 0;
        base = done_tot;
        while (done_tot == base && n < 200) begin tick(); n++; end
        chk(nm, int'(done_tot > base), 1);
    endtask

    task automatic pulse_out(input int n);
        for (int i = 0; i < n; i++) begin
            sc_dout_valid = 1'b1;
            tick();
        end
        sc_dout_valid = 1'b0;
    endtask

    task automatic run_frame(input int nin, input int nout, input bit drop_req);
        int base;
        base = rdy_tot;
        wait_rdy(base + nin, "input_timeout");
        if (drop_req) frame_req = 1'b0;
        pulse_out(nout);
        wait_done("done_timeout");
    endtask

    task automatic launch();
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, r0, d0, b0;

        // Reset
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_start", int'(sc_start), 0);

        // 4x3 -> 2x2, source and sink always ready
        src_valid = 1'b1; sc_next_din = 1'b1; snk_ready = 1'b1;
        s0 = start_tot; r0 = rdy_tot; d0 = done_tot;
        launch();
        run_frame(12, 4, 1'b0);
        chk("f1_start_cycles", start_tot - s0, 2);
        chk("f1_accepts", rdy_tot - r0, 12);
        chk("f1_done_pulses", done_tot - d0, 1);
        chk("f1_gap", gap_meas, 5);
        chk("f1_px0_x", lx[0], 0); chk("f1_px0_y", ly[0], 0);
        chk("f1_px1_x", lx[1], 1); chk("f1_px1_y", ly[1], 0);
        chk("f1_px2_x", lx[2], 0); chk("f1_px2_y", ly[2], 1);
        chk("f1_px3_x", lx[3], 1); chk("f1_px3_y", ly[3], 1);
        chk("f1_last_idx", last_idx, 3);
        chk("f1_busy_after", int'(busy), 0);

        // Toggling source valid
        r0 = rdy_tot; b0 = bad_rdy;
        tog_en = 1'b1;
        launch();
        run_frame(12, 4, 1'b0);
        tog_en = 1'b0;
        src_valid = 1'b1;
        chk("tog_accepts", rdy_tot - r0, 12);
        chk("tog_ready_wo_valid", bad_rdy - b0, 0);

        // frame_req held for three frames, config changed inside the first
        s0 = start_tot; d0 = done_tot;
        frame_req = 1'b1;
        tick();
        in_x_res = 11'd1; in_y_res = 11'd1; out_x_res = 11'd0; out_y_res = 11'd0;
        run_frame(12, 4, 1'b0);
        run_frame(4, 1, 1'b0);
        run_frame(4, 1, 1'b1);
        chk("held_done_pulses", done_tot - d0, 3);
        chk("held_start_cycles", start_tot - s0, 6);
        in_x_res = 11'd3; in_y_res = 11'd2; out_x_res = 11'd1; out_y_res = 11'd1;
        tick();

        // Sink stalls for 10 cycles during DRAIN
        r0 = rdy_tot;
        launch();
        wait_rdy(r0 + 12, "stall_input_timeout");
        pulse_out(2);
        d0 = done_tot;
        snk_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_next_dout", int'(sc_next_dout), 0);
        end
        chk("stall_no_done", done_tot - d0, 0);
        chk("stall_busy", int'(busy), 1);
        snk_ready = 1'b1;
        pulse_out(2);
        wait_done("stall_done_timeout");

        // Reset in the middle of STREAM, then a clean frame
        r0 = rdy_tot;
        launch();
        wait_rdy(r0 + 5, "rst_stream_timeout");
        rst = 1'b1;
        tick();
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_src_ready", int'(src_ready), 0);
        chk("midrst_din_valid", int'(sc_din_valid), 0);
        chk("midrst_next_dout", int'(sc_next_dout), 0);
        rst = 1'b0;
        tick();
        r0 = rdy_tot;
        launch();
        run_frame(12, 4, 1'b0);
        chk("midrst_accepts", rdy_tot - r0, 12);

        // Scaler output while idle sets a sticky error
        sc_dout_valid = 1'b1;
        tick();
        sc_dout_valid = 1'b0;
        tick();
        chk("err_idle", int'(err), 1);
        launch();
        run_frame(12, 4, 1'b0);
        chk("err_sticky", int'(err), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("err_cleared", int'(err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
